mpi_slave: RTL

- CPU-side MPI responder inside the DUT. Decodes the asynchronous-style chip-select bus (cpu_cs_n, cpu_rd_n, cpu_we_n, cpu_addr, cpu_data, cpu_rdy_n) driven by the CPU/bench driver.
- Converts each bus access into a single req/ack transaction on an internal register-file port, then returns the ready handshake and read data.
- Bus timeout and protocol-error supervision are included.

---
 rtl/mpi_slave.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mpi_slave.sv
// CPU-side MPI responder: turns each chip-select bus access into one req/ack
// register-file transaction, with bus timeout and protocol-error supervision.
module mpi_slave #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned TIMEOUT_CYC  = 64,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              cpu_cs_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_we_n,
  input  logic [15:0]       cpu_addr,
  inout  logic [31:0]       cpu_data,
  output logic              cpu_rdy_n,
  output logic              reg_req,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_ack,
  output logic              timeout_pulse,
  output logic [7:0]        proto_err_cnt
);

  // state | meaning
  // IDLE  | waiting for cs_n low with exactly one strobe
  // REQ   | reg_req held until reg_ack or timeout
  // DONE  | cpu_rdy_n low (read data driven) until cs_n returns high
  // DRAIN | illegal strobe combination seen; wait for cs_n high
  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t state, state_nxt;

  logic              cs_n_q, rd_n_q, we_n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  logic [7:0]  cnt;
  logic        aborted;
  logic [31:0] rdata_q;
  logic        drive_en;

  logic start_acc, proto_err, abort_det, to_hit;
  logic finish_ok, finish_abort, release_done;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_q <= 1'b1;
      rd_n_q <= 1'b1;
      we_n_q <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      cs_n_q <= cpu_cs_n;
      rd_n_q <= cpu_rd_n;
      we_n_q <= cpu_we_n;
      addr_q <= cpu_addr[ADDR_W-1:0];
      data_q <= cpu_data;
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_acc    = 1'b0;
    proto_err    = 1'b0;
    abort_det    = 1'b0;
    to_hit       = 1'b0;
    finish_ok    = 1'b0;
    finish_abort = 1'b0;
    release_done = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_n_q) begin
          if (rd_n_q != we_n_q) begin
            start_acc = 1'b1;
            state_nxt = REQ;
          end else if (!rd_n_q) begin
            proto_err = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      REQ: begin
        abort_det = cs_n_q && !aborted;
        proto_err = abort_det;
        to_hit    = !reg_ack && (cnt == TO_LAST);
        // An abandoned access still finishes its register transaction, but never answers the CPU.
        if (reg_ack || to_hit) begin
          if (aborted || cs_n_q) begin
            finish_abort = 1'b1;
            state_nxt    = IDLE;
          end else begin
            finish_ok = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (cs_n_q) begin
          release_done = 1'b1;
          state_nxt    = IDLE;
        end
      end
      DRAIN: begin
        if (cs_n_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      reg_req       <= 1'b0;
      reg_wr        <= 1'b0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      cnt           <= '0;
      aborted       <= 1'b0;
      rdata_q       <= '0;
      drive_en      <= 1'b0;
      cpu_rdy_n     <= 1'b1;
      timeout_pulse <= 1'b0;
      proto_err_cnt <= '0;
    end else begin
      timeout_pulse <= to_hit;
      if (start_acc) begin
        reg_req   <= 1'b1;
        reg_wr    <= !we_n_q;
        reg_addr  <= addr_q;
        reg_wdata <= data_q;
        cnt       <= '0;
        aborted   <= 1'b0;
      end
      if (state == REQ) begin
        cnt <= cnt + 8'd1;
        if (abort_det) aborted <= 1'b1;
      end
      if (finish_ok || finish_abort) reg_req <= 1'b0;
      if (finish_ok) begin
        cpu_rdy_n <= 1'b0;
        drive_en  <= !reg_wr;
        rdata_q   <= to_hit ? TIMEOUT_DATA : reg_rdata;
      end
      if (release_done) begin
        cpu_rdy_n <= 1'b1;
        drive_en  <= 1'b0;
      end
      if (proto_err && (proto_err_cnt != 8'hFF)) proto_err_cnt <= proto_err_cnt + 8'd1;
    end
  end

  assign cpu_data = drive_en ? rdata_q : 'z;

endmodule
